// File: rtl/mult_fu_pkg.sv
// Shared multiply-FU types: issue packet, CDB result record, func encoding.
package mult_fu_pkg;

  localparam int NUM_FU_MULT = 2;
  localparam int DEST_W      = 6;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  typedef struct packed {
    logic              valid;
    MULT_FUNC          func;
    logic [31:0]       rs1_value;
    logic [31:0]       rs2_value;
    logic [DEST_W-1:0] dest_reg_idx;
    logic [31:0]       inst;
  } MULT_PACKET;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest_reg_idx;
    logic [31:0]       value;
  } CDB_REG_PACKET;

  function automatic logic [63:0] mult_ext(logic [31:0] v, logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

  function automatic logic [31:0] mult_sel(MULT_FUNC f, logic [63:0] prod);
    return (f == MUL) ? prod[31:0] : prod[63:32];
  endfunction

endpackage

// File: rtl/mult_fu_if.sv
// Issue->execute and CDB-side signals of one multiply FU.
interface mult_fu_if;
  import mult_fu_pkg::*;

  MULT_PACKET    mult_packet;
  logic          mult_free;
  logic          mult_cdb_req;
  logic          mult_cdb_gnt;
  CDB_REG_PACKET mult_result;
  CDB_REG_PACKET early_tag;

  modport master (
    output mult_packet, mult_cdb_gnt,
    input  mult_free, mult_cdb_req, mult_result, early_tag
  );

  modport slave (
    input  mult_packet, mult_cdb_gnt,
    output mult_free, mult_cdb_req, mult_result, early_tag
  );
endinterface

// File: rtl/mult_stage.sv
// One combinational shift-add step: folds STEP_W multiplier bits into the partial product.
module mult_stage #(
  parameter int STEP_W = 16
) (
  input  logic [63:0] mcand_i,
  input  logic [63:0] mplier_i,
  input  logic [63:0] partial_i,
  output logic [63:0] mcand_o,
  output logic [63:0] mplier_o,
  output logic [63:0] partial_o
);

  always_comb begin
    partial_o = partial_i;
    for (int j = 0; j < STEP_W; j++)
      if (mplier_i[j]) partial_o = partial_o + (mcand_i << j);
  end

  assign mcand_o  = mcand_i << STEP_W;
  assign mplier_o = mplier_i >> STEP_W;

endmodule

// File: rtl/mult_fu.sv
// Pipelined 32x32 integer multiply FU with CDB request/grant backpressure.
// Optional MULT_EARLY_TAG_EN adds a tag-only wakeup one cycle ahead of mult_result.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int MULT_STAGES = 4
) (
  input logic      clock,
  input logic      reset_n,
  mult_fu_if.slave io
);

  localparam int S      = MULT_STAGES;
  localparam int STEP_W = 64 / S;

  typedef struct packed {
    logic              valid;
    MULT_FUNC          func;
    logic [DEST_W-1:0] dest;
    logic [63:0]       mcand;
    logic [63:0]       mplier;
    logic [63:0]       partial;
  } MULT_STAGE_DATA;

  MULT_STAGE_DATA stage_q [S];
  MULT_STAGE_DATA stage_d [S];

  logic [63:0] in_mcand   [S];
  logic [63:0] in_mplier  [S];
  logic [63:0] in_part    [S];
  logic [63:0] out_mcand  [S];
  logic [63:0] out_mplier [S];
  logic [63:0] out_part   [S];

  MULT_PACKET pkt;
  logic       req, stall;

  assign pkt   = io.mult_packet;
  assign req   = stage_q[S-2].valid;
  assign stall = req & ~io.mult_cdb_gnt;

  assign io.mult_cdb_req = req;
  assign io.mult_free    = ~stall;

  // Step k is applied on the way into stage k, so stage S-1 holds the full product.
  genvar i;
  generate
    for (i = 0; i < S; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign in_mcand[i]  = mult_ext(pkt.rs1_value, pkt.func != MULHU);
        assign in_mplier[i] = mult_ext(pkt.rs2_value, (pkt.func == MUL) || (pkt.func == MULH));
        assign in_part[i]   = '0;
      end else begin : g_body
        assign in_mcand[i]  = stage_q[i-1].mcand;
        assign in_mplier[i] = stage_q[i-1].mplier;
        assign in_part[i]   = stage_q[i-1].partial;
      end
      mult_stage #(.STEP_W(STEP_W)) u_stage (
        .mcand_i   (in_mcand[i]),
        .mplier_i  (in_mplier[i]),
        .partial_i (in_part[i]),
        .mcand_o   (out_mcand[i]),
        .mplier_o  (out_mplier[i]),
        .partial_o (out_part[i])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < S; k++) stage_d[k] = stage_q[k];
    if (!stall) begin
      stage_d[0].valid = pkt.valid;
      stage_d[0].func  = pkt.func;
      stage_d[0].dest  = pkt.dest_reg_idx;
      for (int k = 1; k < S; k++) begin
        stage_d[k].valid = stage_q[k-1].valid;
        stage_d[k].func  = stage_q[k-1].func;
        stage_d[k].dest  = stage_q[k-1].dest;
      end
      for (int k = 0; k < S; k++) begin
        stage_d[k].mcand   = out_mcand[k];
        stage_d[k].mplier  = out_mplier[k];
        stage_d[k].partial = out_part[k];
      end
    end else begin
      // Front of the pipe freezes; the op just broadcast is replaced by a bubble.
      stage_d[S-1] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < S; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < S; k++) stage_q[k] <= stage_d[k];
    end
  end

  always_comb begin
    io.mult_result              = '0;
    io.mult_result.valid        = stage_q[S-1].valid;
    io.mult_result.dest_reg_idx = stage_q[S-1].dest;
    io.mult_result.value        = mult_sel(stage_q[S-1].func, stage_q[S-1].partial);
  end

`ifdef MULT_EARLY_TAG_EN
  always_comb begin
    io.early_tag = '0;
    if (req && io.mult_cdb_gnt) begin
      io.early_tag.valid        = 1'b1;
      io.early_tag.dest_reg_idx = stage_q[S-2].dest;
    end
  end
`else
  assign io.early_tag = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{pkt.inst, stage_q[S-1].mcand, stage_q[S-1].mplier};

endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit on the execute side of the issue→execute interface. It accepts `MULT_PACKET`s from issue and returns `mult_free` backpressure. It raises `mult_cdb_req` one cycle before a result is ready, and drives the completed product plus destination tag onto its CDB slot after `mult_cdb_gnt`. The issue stage instantiates `NUM_FU_MULT` copies.

## Interface
- `MULT_STAGES`, 4: pipeline depth; legal values 2, 4, 8 (must divide 64).
- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `mult_packet` input `MULT_PACKET`: issued instruction with `valid`, `func` (MUL/MULH/MULHSU/MULHU), `rs1_value`, `rs2_value`, `dest_reg_idx`, `inst`.
- `mult_free` output 1: FU can capture `mult_packet` this cycle.
- `mult_cdb_req` output 1: stage `MULT_STAGES-2` holds a valid op.
- `mult_cdb_gnt` input 1: CDB slot granted for the op that is requesting.
- `mult_result` output `CDB_REG_PACKET`: `valid`, `dest_reg_idx`, `value`.
- `early_tag` output `CDB_REG_PACKET`: tag-only wakeup, one cycle before `mult_result`. Exists only with the macro; see Configuration.

## Operation
- Stages 0..S-1 (S=`MULT_STAGES`), each holds valid, func, dest tag, multiplicand, remaining multiplier, partial product (64b).
- Operands are sign- or zero-extended to 64b per func: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned. Product is taken mod 2^64.
- Each stage adds 64/S multiplier bits' worth of shifted multiplicand into the partial product.
- Result select: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32].
- stall = `mult_cdb_req` && !`mult_cdb_gnt`.
- `mult_free` = !stall (combinational from `mult_cdb_gnt`). Issue must only drive a valid packet when `mult_free` is high. A valid packet with `mult_free` low is ignored.
- No stall: all stages shift one step. Stage 0 loads `mult_packet` (bubble if not valid).
- Stall: stages 0..S-2 hold. Stage S-1 loads a bubble.
- No bubble collapsing; a stall freezes the whole front of the pipe.
- `mult_result` is registered from stage S-1. Its valid bit is high for exactly one cycle per op.

## Timing
- Reset (async assert): all stage valid bits 0. `mult_result.valid`=0, `mult_cdb_req`=0, `mult_free`=1, `early_tag.valid`=0. Other fields are 0.
- Packet accepted in cycle t, no stalls: `mult_cdb_req` high in t+S-1, `mult_result.valid` in t+S.
- Each cycle of `mult_cdb_req` without a grant delays every in-flight op by one cycle.
- Back-to-back issue sustains one op per cycle when grants keep up.
- Reset deassertion mid-operation: all in-flight ops are lost. No output goes valid until a new accept.
- An accept and a grant in the same cycle are both honored.

## Configuration
- `MULT_EARLY_TAG_EN` defined: `early_tag.valid`=1 and `early_tag.dest_reg_idx` = stage S-2 tag in any cycle where `mult_cdb_req`&&`mult_cdb_gnt`; `value`=0. This lets the RS wake dependents so they issue in step with `mult_result`.
- Not defined: `early_tag` is driven to all zeros.

## Structure
- Shared `sys_defs` gets: `MULT_FUNC` enum, `MULT_PACKET`, `CDB_REG_PACKET`, `NUM_FU_MULT`.
- Stage register record typedef `MULT_STAGE_DATA` stays local.
- One sub-module, `mult_stage`: combinational partial-product step (multiplicand, multiplier slice, partial in → updated partial, shifted operands out). Instantiated S times; `mult_fu` owns all registers and stall control.

## Test plan
- Reset with `reset_n`=0 → `mult_free`=1, `mult_cdb_req`=0, `mult_result.valid`=0. Then MUL 7×6 dest 12, gnt always 1 → cycle t+4 result valid, value 42, tag 12.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MUL −3×5 → 0xFFFFFFF1.
- Four back-to-back ops, gnt held 0 for 3 cycles at first request → `mult_free`=0 those 3 cycles, results arrive in order on consecutive cycles after gnt, no loss or duplication.
- Valid packet driven while `mult_free`=0 → ignored; no extra result appears.
- Assert `reset_n` low with 3 ops in flight → outputs clear immediately; after release, no spurious `mult_result.valid`.
- With `MULT_EARLY_TAG_EN`: `early_tag` tag equals the next cycle's `mult_result` tag for each op. Without it: `early_tag` stays 0.
